// File: rtl/decryption_pkg.sv
// rtl/decryption_pkg.sv - shared constants and FSM state type for the decryption stages
package decryption_pkg;

  localparam int                D_WIDTH                = 8;
  localparam int                KEY_WIDTH              = 8;
  localparam int                MAX_NOF_CHARS          = 50;
  localparam logic [D_WIDTH-1:0] START_DECRYPTION_TOKEN = 8'hFA;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_DECRYPT = 2'd1,
    ST_FLUSH   = 2'd2
  } state_t;

endpackage

// File: rtl/scytale_char_buffer.sv
// rtl/scytale_char_buffer.sv - ciphertext byte store with one write port and a registered read
module scytale_char_buffer #(
  parameter int D_WIDTH = 8,
  parameter int DEPTH   = 50,
  parameter int AW      = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_wr_en,
  input  logic [AW-1:0]      i_wr_addr,
  input  logic [D_WIDTH-1:0] i_wr_data,
  input  logic               i_rd_en,
  input  logic [AW-1:0]      i_rd_addr,
  output logic [D_WIDTH-1:0] o_rd_data
);

  logic [D_WIDTH-1:0] r_mem [DEPTH];
  logic [D_WIDTH-1:0] r_rd_data;

  // Storage array; contents carry no reset so it maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  // Read register doubles as the plaintext output register, so it is reset to 0.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rd_data <= '0;
    end else if (i_rd_en) begin
      r_rd_data <= r_mem[i_rd_addr];
    end
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/scytale_decryption.sv
// rtl/scytale_decryption.sv - streaming Scytale decryption: collect, validate, emit transposed
module scytale_decryption #(
  parameter int                  D_WIDTH                = decryption_pkg::D_WIDTH,
  parameter int                  KEY_WIDTH              = decryption_pkg::KEY_WIDTH,
  parameter int                  MAX_NOF_CHARS          = decryption_pkg::MAX_NOF_CHARS,
  parameter logic [D_WIDTH-1:0]  START_DECRYPTION_TOKEN = decryption_pkg::START_DECRYPTION_TOKEN
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [D_WIDTH-1:0]   data_i,
  input  logic                 valid_i,
  input  logic [KEY_WIDTH-1:0] key_N,
  input  logic [KEY_WIDTH-1:0] key_M,
  output logic                 busy,
  output logic [D_WIDTH-1:0]   data_o,
  output logic                 valid_o,
  output logic                 err_o
);

  import decryption_pkg::*;

  localparam int CW = $clog2(MAX_NOF_CHARS + 1);
  localparam int AW = $clog2(MAX_NOF_CHARS);
  localparam int PW = 2 * KEY_WIDTH;

  state_t               r_state, w_state_nxt;
  logic [CW-1:0]        r_count, w_count_nxt;
  logic                 r_ovf, w_ovf_nxt;
  logic [KEY_WIDTH-1:0] r_i, w_i_nxt;
  logic [KEY_WIDTH-1:0] r_j, w_j_nxt;
  logic [KEY_WIDTH-1:0] r_n, w_n_nxt;
  logic [KEY_WIDTH-1:0] r_m, w_m_nxt;
  logic                 r_busy, w_busy_nxt;
  logic                 r_valid, w_valid_nxt;
  logic                 r_err, w_err_nxt;

  logic                 w_wr_en;
  logic                 w_rd_en;
  logic [AW-1:0]        w_rd_addr;
  logic [PW-1:0]        w_prod;
  logic                 w_accept;

  // Key product must equal the byte count exactly; the 0xFFFF reset key can never match.
  assign w_prod   = PW'(key_N) * PW'(key_M);
  assign w_accept = (r_count != '0) && !r_ovf && (w_prod == PW'(r_count));

  // Row-major buffer index of the byte emitted on the next edge; valid messages never exceed the buffer.
  assign w_rd_addr = AW'(r_j) * AW'(r_n) + AW'(r_i);

  scytale_char_buffer #(
    .D_WIDTH (D_WIDTH),
    .DEPTH   (MAX_NOF_CHARS),
    .AW      (AW)
  ) u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_wr_en   (w_wr_en),
    .i_wr_addr (AW'(r_count)),
    .i_wr_data (data_i),
    .i_rd_en   (w_rd_en),
    .i_rd_addr (w_rd_addr),
    .o_rd_data (data_o)
  );

  // State and control registers; buffer contents live in the sub-module and are not cleared.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_count <= '0;
      r_ovf   <= 1'b0;
      r_i     <= '0;
      r_j     <= '0;
      r_n     <= '0;
      r_m     <= '0;
      r_busy  <= 1'b0;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
      r_ovf   <= w_ovf_nxt;
      r_i     <= w_i_nxt;
      r_j     <= w_j_nxt;
      r_n     <= w_n_nxt;
      r_m     <= w_m_nxt;
      r_busy  <= w_busy_nxt;
      r_valid <= w_valid_nxt;
      r_err   <= w_err_nxt;
    end
  end

  // Next-state logic: collect until the token, validate, then walk columns of the M x N grid.
  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_ovf_nxt   = r_ovf;
    w_i_nxt     = r_i;
    w_j_nxt     = r_j;
    w_n_nxt     = r_n;
    w_m_nxt     = r_m;
    w_busy_nxt  = r_busy;
    w_valid_nxt = 1'b0;
    w_err_nxt   = 1'b0;
    w_wr_en     = 1'b0;
    w_rd_en     = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (valid_i) begin
          if (data_i == START_DECRYPTION_TOKEN) begin
            if (w_accept) begin
              w_n_nxt     = key_N;
              w_m_nxt     = key_M;
              w_busy_nxt  = 1'b1;
              w_i_nxt     = '0;
              w_j_nxt     = '0;
              w_state_nxt = ST_DECRYPT;
            end else begin
              w_err_nxt   = 1'b1;
              w_count_nxt = '0;
              w_ovf_nxt   = 1'b0;
            end
          end else if (r_count == CW'(MAX_NOF_CHARS)) begin
            w_ovf_nxt = 1'b1;
          end else begin
            w_wr_en     = 1'b1;
            w_count_nxt = r_count + 1'b1;
          end
        end
      end

      ST_DECRYPT: begin
        w_rd_en     = 1'b1;
        w_valid_nxt = 1'b1;
        if (r_j == r_m - 1'b1) begin
          w_j_nxt = '0;
          if (r_i == r_n - 1'b1) begin
            w_state_nxt = ST_FLUSH;
          end else begin
            w_i_nxt = r_i + 1'b1;
          end
        end else begin
          w_j_nxt = r_j + 1'b1;
        end
      end

      ST_FLUSH: begin
        w_busy_nxt  = 1'b0;
        w_count_nxt = '0;
        w_state_nxt = ST_IDLE;
      end

      default: begin
        w_busy_nxt  = 1'b0;
        w_count_nxt = '0;
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign busy    = r_busy;
  assign valid_o = r_valid;
  assign err_o   = r_err;

endmodule

// File: tb/tb_scytale_decryption.sv
// tb/tb_scytale_decryption.sv - randomized scoreboard bench for scytale_decryption
module tb_scytale_decryption;

  localparam logic [7:0] TOK = 8'hFA;

  logic       clk     = 1'b0;
  logic       rst_n   = 1'b0;
  logic       valid_i = 1'b0;
  logic [7:0] data_i  = 8'h00;
  logic [7:0] key_N   = 8'hFF;
  logic [7:0] key_M   = 8'hFF;
  logic       busy;
  logic       valid_o;
  logic       err_o;
  logic [7:0] data_o;

  int n_cmp = 0;
  int n_mis = 0;

  logic [7:0] exp_q[$];
  int         busy_q[$];
  int         err_pending = 0;
  logic [7:0] msg_q[$];
  logic [7:0] plain_q[$];
  bit         mon_en = 1'b0;
  bit         gaps   = 1'b0;
  int         busy_run = 0;

  always #5 clk = ~clk;

  scytale_decryption dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .data_i  (data_i),
    .valid_i (valid_i),
    .key_N   (key_N),
    .key_M   (key_M),
    .busy    (busy),
    .data_o  (data_o),
    .valid_o (valid_o),
    .err_o   (err_o)
  );

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference: ciphertext is an M-row by N-column grid written row by row; plaintext reads it column by column.
  task automatic model(input int n, input int m);
    plain_q.delete();
    for (int c = 0; c < n; c++)
      for (int r = 0; r < m; r++)
        plain_q.push_back(msg_q[r * n + c]);
  endtask

  task automatic load(input string s);
    msg_q.delete();
    for (int k = 0; k < s.len(); k++) msg_q.push_back(s[k]);
  endtask

  task automatic load_rand(input int len);
    logic [7:0] b;
    msg_q.delete();
    for (int k = 0; k < len; k++) begin
      b = 8'($urandom_range(0, 255));
      if (b == TOK) b = 8'h00;
      msg_q.push_back(b);
    end
  endtask

  task automatic drive(input logic [7:0] b);
    @(negedge clk);
    valid_i = 1'b1;
    data_i  = b;
  endtask

  task automatic idle();
    @(negedge clk);
    valid_i = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int t = 0;
    while ((exp_q.size() != 0 || busy_q.size() != 0 || err_pending != 0 || busy) && t < 300) begin
      @(negedge clk);
      t++;
    end
    check({name, "_done"}, int'(t < 300), 1);
  endtask

  task automatic expect_msg(input int n, input int m);
    int len = msg_q.size();
    if (len != 0 && len <= 50 && n * m == len) begin
      model(n, m);
      foreach (plain_q[k]) exp_q.push_back(plain_q[k]);
      busy_q.push_back(len + 1);
    end else begin
      err_pending++;
    end
  endtask

  task automatic send_msg(input int n, input int m, input string name);
    key_N = 8'(n);
    key_M = 8'(m);
    expect_msg(n, m);
    foreach (msg_q[k]) begin
      if (gaps && $urandom_range(0, 3) == 0) idle();
      drive(msg_q[k]);
    end
    drive(TOK);
    idle();
    wait_done(name);
  endtask

  // Monitor: pops the scoreboard on every output event and measures each busy window.
  always @(negedge clk) begin
    if (!mon_en) begin
      busy_run = 0;
    end else begin
      if (valid_o) begin
        check("valid_o_needs_busy", int'(busy), 1);
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_mis++;
          $display("FAIL unexpected_output: got data_o=%0d, expected no output", data_o);
        end else begin
          check("data_o", int'(data_o), int'(exp_q.pop_front()));
        end
      end
      if (err_o) begin
        check("err_without_busy", int'(busy), 0);
        if (err_pending == 0) begin
          n_cmp++;
          n_mis++;
          $display("FAIL unexpected_err: got err_o=1, expected 0");
        end else begin
          err_pending--;
        end
      end
      if (busy) begin
        busy_run++;
      end else if (busy_run > 0) begin
        if (busy_q.size() == 0) begin
          n_cmp++;
          n_mis++;
          $display("FAIL unexpected_busy: got busy window %0d, expected none", busy_run);
        end else begin
          check("busy_len", busy_run, busy_q.pop_front());
        end
        busy_run = 0;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1);
  end

  initial begin
    int n, m, len;

    repeat (3) @(negedge clk);
    check("rst_busy",    int'(busy),    0);
    check("rst_valid_o", int'(valid_o), 0);
    check("rst_data_o",  int'(data_o),  0);
    check("rst_err_o",   int'(err_o),   0);
    rst_n  = 1'b1;
    mon_en = 1'b1;
    @(negedge clk);

    load("ADBECF");
    send_msg(2, 3, "basic_2x3");

    load("AB");
    send_msg(255, 255, "unconfigured_key");

    load("ABC");
    send_msg(2, 2, "count_mismatch");
    load("ACBD");
    send_msg(2, 2, "after_error");

    load_rand(51);
    send_msg(5, 10, "overflow");

    load_rand(50);
    send_msg(5, 10, "full_buffer");

    load("XYZ");
    key_N = 8'd3;
    key_M = 8'd1;
    expect_msg(3, 1);
    foreach (msg_q[k]) drive(msg_q[k]);
    drive(TOK);
    repeat (4) begin
      @(negedge clk);
      valid_i = 1'b1;
      data_i  = "Q";
      key_N   = 8'd7;
    end
    idle();
    wait_done("input_while_busy");
    load("MN");
    send_msg(1, 2, "after_busy_input");

    load("HELLO!");
    key_N  = 8'd2;
    key_M  = 8'd3;
    mon_en = 1'b0;
    foreach (msg_q[k]) drive(msg_q[k]);
    drive(TOK);
    idle();
    check("midrst_busy", int'(busy), 1);
    @(negedge clk);
    model(2, 3);
    check("midrst_valid_o", int'(valid_o), 1);
    check("midrst_data_o",  int'(data_o),  int'(plain_q[0]));
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_valid_after", int'(valid_o), 0);
    check("midrst_busy_after",  int'(busy),    0);
    check("midrst_err_after",   int'(err_o),   0);
    rst_n  = 1'b1;
    mon_en = 1'b1;
    load("HELLO!");
    send_msg(2, 3, "after_reset");

    gaps = 1'b1;
    for (int r = 0; r < 25; r++) begin
      n   = $urandom_range(1, 10);
      m   = $urandom_range(1, 50 / n);
      len = n * m;
      if ($urandom_range(0, 3) == 0) len = (len > 1 && $urandom_range(0, 1) == 1) ? len - 1 : len + 1;
      load_rand(len);
      send_msg(n, m, "random");
    end

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
